hazard_sched: RTL
=================

# hazard_sched

Pipeline hazard scheduler for the five-stage core. It compares decode-stage source registers against destinations in EX/MEM/WB and drives stall, flush and forwarding-select lines. It also owns the control unit's `harzard` input and sequences the terminate drain into a halt state. It sits beside the decode-stage control unit and steers the IF/ID and ID/EX pipeline registers and the EX operand muxes.

## Interface
- `REG_W`, default 5: register-index width.
- `DRAIN_CYC`, default 3: cycles to retire EX/MEM/WB after terminate.
- `CNT_W`, default 32: stall performance-counter width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rs_d`, `rt_d` input REG_W: decode-stage source indices.
- `use_rs_d`, `use_rt_d` input 1: decoded instruction reads that source.
- `is_branch_d`, `branch_taken_d`, `jump_taken_d`, `terminate_d` input 1: from the control unit.
- `rd_e`, `rd_m`, `rd_w` input REG_W: destination index per stage.
- `wb_en_e`, `wb_en_m`, `wb_en_w` input 1: stage will write back.
- `mem_r_e`, `mem_r_m` input 1: stage holds a load.
- `stall_f`, `stall_d` output 1: hold PC and the IF/ID register.
- `flush_d`, `flush_e` output 1: zero IF/ID; insert a bubble into ID/EX.
- `harzard` output 1: gates the control unit's side-effect outputs.
- `fwd_a_e`, `fwd_b_e` output 2: EX operand select; 00 = ID/EX, 01 = WB, 10 = MEM.
- `fwd_a_d`, `fwd_b_d` output 1: decode comparator takes the MEM result.
- `halted` output 1: core has drained after terminate.
- `stall_cnt` output CNT_W: count of stall cycles.

## Operation
- The FSM has four states: RUN, DRAIN, HALT and STALL_HOLD.
- A match in a stage means: that stage's wb_en is 1, its rd equals the source, the source's use bit is 1, and rd ≠ 0.
- Load-use hazard: an E match with mem_r_e=1.
- Branch hazard: is_branch_d or a jump-register, with either an E match (any producer) or an M match with mem_r_m=1.
- RUN behaviour:
  - On any hazard: stall_f=stall_d=flush_e=harzard=1.
  - A branch hazard caused by a load in E needs two cycles. The FSM enters STALL_HOLD for the second cycle and returns to RUN after it.
  - With no hazard and branch_taken_d or jump_taken_d: flush_d=1 for one cycle; no stall.
  - terminate_d with no hazard: flush_d=1, go to DRAIN, load the drain counter with DRAIN_CYC-1.
- DRAIN: stall_f=stall_d=1, flush_e=1, harzard=1. The counter decrements each cycle. At 0 the FSM moves to HALT.
- HALT: halted=1, stall_f=stall_d=flush_e=harzard=1. Only reset leaves HALT.
- Forwarding, priority MEM over WB:
  - fwd_x_e=10 on a MEM match with mem_r_m=0.
  - Else fwd_x_e=01 on a WB match.
  - Else 00.
- fwd_x_d=1 on a MEM match with mem_r_m=0.
- stall_cnt increments in every cycle where stall_d=1 and state≠HALT. It saturates at all-ones.
- Simultaneous events:
  - Hazard beats branch/jump flush: no flush_d while stalling. The flush is taken once the stall resolves.
  - Hazard beats terminate: terminate is acted on when no longer stalled.

## Timing
- Hazard, flush and forwarding outputs are combinational from current inputs and the registered state. Zero-cycle latency.
- State, drain counter and stall_cnt update on the rising edge of clk.
- Reset (async, rst_n=0) effects:
  - state=RUN, drain counter=0, stall_cnt=0, halted=0.
  - All combinational outputs are forced to 0 while rst_n=0.
- Reset mid-DRAIN or in HALT returns to RUN immediately. No counts are retained.
- Load-use costs exactly 1 bubble. Branch on an ALU result costs 1; branch on a load costs 2.
- halted rises exactly DRAIN_CYC cycles after the edge that samples terminate_d in RUN.

## Configuration
- `HAZARD_FORWARD_EN` defined: forwarding as above; only load-use and branch hazards stall.
- `HAZARD_FORWARD_EN` undefined:
  - fwd_a_e, fwd_b_e, fwd_a_d and fwd_b_d are tied to 0.
  - Any E or M match stalls, whether or not it is a load.
  - WB matches never stall; the register file writes through.
  - STALL_HOLD is unused.

## Test plan
- Back-to-back dependency: add r3 in E (wb_en_e=1, rd_e=3), then rs_d=3 → with the macro, no stall and one cycle later fwd_a_e=10; without the macro, stall_d=1 for 2 cycles, stall_cnt=2.
- Load-use: lw r4 in E, rt_d=4 → stall_d=flush_e=harzard=1 for exactly 1 cycle, then fwd_b_e=10 is not selected for a load (WB gives 01 the following cycle).
- Branch on a load: beq rs_d=5 with lw r5 in E → 2 stall cycles (RUN→STALL_HOLD→RUN); then branch_taken_d=1 gives flush_d=1 for 1 cycle.
- rd=0 writer in E/M/W while rs_d=0 → no stall, all fwd=00.
- Terminate: terminate_d=1 in RUN → flush_d that cycle; halted=1 three edges later and stays high; stall_cnt stops counting in HALT.
- Reset asserted mid-DRAIN (counter=1) → all outputs are 0 immediately; after release, state is RUN and halted=0.

Source files
------------

// File: rtl/hazard_sched_if.sv
// Hazard scheduler signal bundle: decode/EX/MEM/WB hazard inputs and stall/flush/forward outputs.
interface hazard_sched_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
);
  logic [REG_W-1:0] rs_d, rt_d, rd_e, rd_m, rd_w;
  logic             use_rs_d, use_rt_d;
  logic             is_branch_d, branch_taken_d, jump_taken_d, terminate_d;
  logic             wb_en_e, wb_en_m, wb_en_w;
  logic             mem_r_e, mem_r_m;
  logic             stall_f, stall_d, flush_d, flush_e, harzard, halted;
  logic [1:0]       fwd_a_e, fwd_b_e;
  logic             fwd_a_d, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs_d, rt_d, rd_e, rd_m, rd_w, use_rs_d, use_rt_d,
           is_branch_d, branch_taken_d, jump_taken_d, terminate_d,
           wb_en_e, wb_en_m, wb_en_w, mem_r_e, mem_r_m,
    input  stall_f, stall_d, flush_d, flush_e, harzard, halted,
           fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_cnt
  );

  modport slave (
    input  rs_d, rt_d, rd_e, rd_m, rd_w, use_rs_d, use_rt_d,
           is_branch_d, branch_taken_d, jump_taken_d, terminate_d,
           wb_en_e, wb_en_m, wb_en_w, mem_r_e, mem_r_m,
    output stall_f, stall_d, flush_d, flush_e, harzard, halted,
           fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_cnt
  );
endinterface

// File: rtl/hazard_sched.sv
// Five-stage pipeline hazard scheduler: stall/flush/forward control and terminate drain to halt.
// Optional macro HAZARD_FORWARD_EN enables operand forwarding (otherwise any E/M match stalls).
module hazard_sched #(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned CNT_W     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_sched_if.slave hz
);
  localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT, S_STALL_HOLD} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [REG_W-1:0] rs, rt;
  logic mE_a, mE_b, mM_a, mM_b, mW_a, mW_b, mE, mM;
  logic br_chk, br_haz, br_load, hazard;
  logic stall, flush_d, flush_e, harz, halted;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic fwd_a_d, fwd_b_d;

  function automatic logic match(input logic wb, input logic [REG_W-1:0] rd,
                                 input logic [REG_W-1:0] src, input logic use_src);
    return wb && use_src && (rd == src) && (rd != '0);
  endfunction

  assign rs   = hz.rs_d;
  assign rt   = hz.rt_d;
  assign mE_a = match(hz.wb_en_e, hz.rd_e, rs, hz.use_rs_d);
  assign mE_b = match(hz.wb_en_e, hz.rd_e, rt, hz.use_rt_d);
  assign mM_a = match(hz.wb_en_m, hz.rd_m, rs, hz.use_rs_d);
  assign mM_b = match(hz.wb_en_m, hz.rd_m, rt, hz.use_rt_d);
  assign mW_a = match(hz.wb_en_w, hz.rd_w, rs, hz.use_rs_d);
  assign mW_b = match(hz.wb_en_w, hz.rd_w, rt, hz.use_rt_d);
  assign mE   = mE_a | mE_b;
  assign mM   = mM_a | mM_b;

  // A taken jump that reads rs is a jump-register and resolves in decode like a branch.
  assign br_chk  = hz.is_branch_d | (hz.jump_taken_d & hz.use_rs_d);
  assign br_haz  = br_chk & (mE | (mM & hz.mem_r_m));
  assign br_load = br_chk & mE & hz.mem_r_e;

`ifdef HAZARD_FORWARD_EN
  assign hazard  = (mE & hz.mem_r_e) | br_haz;
  assign fwd_a_e = (mM_a && !hz.mem_r_m) ? 2'b10 : (mW_a ? 2'b01 : 2'b00);
  assign fwd_b_e = (mM_b && !hz.mem_r_m) ? 2'b10 : (mW_b ? 2'b01 : 2'b00);
  assign fwd_a_d = mM_a & ~hz.mem_r_m;
  assign fwd_b_d = mM_b & ~hz.mem_r_m;
`else
  logic unused_fwd;
  assign hazard     = mE | mM;
  assign fwd_a_e    = '0;
  assign fwd_b_e    = '0;
  assign fwd_a_d    = 1'b0;
  assign fwd_b_d    = 1'b0;
  assign unused_fwd = ^{mW_a, mW_b, br_haz, br_load};
`endif

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    stall   = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    harz    = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (hazard) begin
          stall   = 1'b1;
          flush_e = 1'b1;
          harz    = 1'b1;
`ifdef HAZARD_FORWARD_EN
          if (br_load) state_d = S_STALL_HOLD;
`endif
        end else if (hz.terminate_d) begin
          flush_d = 1'b1;
          state_d = S_DRAIN;
          drain_d = DW'(DRAIN_CYC - 1);
        end else if (hz.branch_taken_d || hz.jump_taken_d) begin
          flush_d = 1'b1;
        end
      end
      S_STALL_HOLD: begin
        stall   = 1'b1;
        flush_e = 1'b1;
        harz    = 1'b1;
        state_d = S_RUN;
      end
      S_DRAIN: begin
        stall   = 1'b1;
        flush_e = 1'b1;
        harz    = 1'b1;
        if (drain_q == '0) state_d = S_HALT;
        else               drain_d = drain_q - DW'(1);
      end
      S_HALT: begin
        stall   = 1'b1;
        flush_e = 1'b1;
        harz    = 1'b1;
        halted  = 1'b1;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (state_q != S_HALT) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Everything combinational is held low while reset is asserted.
  assign hz.stall_f   = rst_n & stall;
  assign hz.stall_d   = rst_n & stall;
  assign hz.flush_d   = rst_n & flush_d;
  assign hz.flush_e   = rst_n & flush_e;
  assign hz.harzard   = rst_n & harz;
  assign hz.halted    = rst_n & halted;
  assign hz.fwd_a_e   = rst_n ? fwd_a_e : 2'b00;
  assign hz.fwd_b_e   = rst_n ? fwd_b_e : 2'b00;
  assign hz.fwd_a_d   = rst_n & fwd_a_d;
  assign hz.fwd_b_d   = rst_n & fwd_b_d;
  assign hz.stall_cnt = stall_cnt_q;
endmodule
